// File: rtl/riscv_pkg.sv
// Core-wide constants shared by the fetch front end, decode and flush logic.
package riscv_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int              FETCH_DEPTH      = 2;
  localparam logic [31:0]     INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, EX redirect and the IF/ID handshake.
interface fetch_pc_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [31:0]     out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_instr,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_instr,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} between the instruction memory and decode.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic [31:0]     push_instr_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [1:0]      count_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [31:0]     head_instr_o
);

  logic [1:0]      count_q, count_d;
  logic [XLEN-1:0] pc_q    [FETCH_DEPTH];
  logic [31:0]     instr_q [FETCH_DEPTH];
  logic            pop_ok;
  logic            push_ok;
  logic            wr_idx;

  assign pop_ok  = pop_i & (count_q != 2'd0);
  assign push_ok = push_i & ((count_q != 2'd2) | pop_ok);

  // Entry 0 is always the head; a pop shifts entry 1 down, so a push lands right behind what survives.
  assign wr_idx = (count_q == 2'd2) | ((count_q == 2'd1) & ~pop_ok);

  // NOTE: combinational logic uses blocking '=' and assigns a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is not reset; every read is qualified by count_q, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (pop_ok) begin
        pc_q[0]    <= pc_q[1];
        instr_q[0] <= instr_q[1];
      end
      if (push_ok) begin
        pc_q[wr_idx]    <= push_pc_i;
        instr_q[wr_idx] <= push_instr_i;
      end
    end
  end

  assign count_o      = count_q;
  assign head_pc_o    = pc_q[0];
  assign head_instr_o = instr_q[0];

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch front end: PC register, credit-limited requests to a 1-cycle imem,
// a 2-entry fetch queue toward decode, and redirect squashing.
module fetch_pc_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  fetch_pc_stage_if.master bus
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic            req;
  logic            pop;
  logic            push;
  logic            head_valid;
  logic [1:0]      count;
  logic [2:0]      credit_used;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;

  assign head_valid = (count != 2'd0);
  assign pop        = head_valid & bus.out_ready;

  // Slots already promised: queued entries plus the response on its way, less the one decode takes now.
  assign credit_used = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign req         = rst_n & ~bus.redirect_valid & (credit_used < 3'(FETCH_DEPTH));
  assign push        = inflight_q & ~kill_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = 1'b0;
    if (bus.redirect_valid) begin
      // The queue flush drops this cycle's response; kill covers anything still marked in flight.
      pc_d   = {bus.redirect_pc[XLEN-1:2], 2'b00};
      kill_d = inflight_q;
    end else if (req) begin
      pc_d          = pc_q + PC_STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end else begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  fetch_queue #(
    .XLEN (XLEN)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_pc_i    (inflight_pc_q),
    .push_instr_i (bus.imem_rdata),
    .pop_i        (pop),
    .flush_i      (bus.redirect_valid),
    .count_o      (count),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr)
  );

  assign bus.imem_req     = req;
  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = head_valid;
  assign bus.out_pc       = head_valid ? head_pc : '0;
  assign bus.out_pc_plus4 = head_valid ? (head_pc + PC_STEP) : '0;
  assign bus.out_instr    = head_valid ? head_instr : '0;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage: a 1-cycle memory model plus a program-order scoreboard.
module tb_fetch_pc_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] SIG    = 32'hA5A5_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_stage_if #(.XLEN(32)) bus ();

  fetch_pc_stage #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks;
  int          errors;
  int          cyc;
  int          first_valid;
  int          hs_count;
  int          req_count;
  int          hs_before;
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  logic        prev_req;
  logic [31:0] prev_addr;
  logic        release_pending;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic reseed(input logic [31:0] target);
    exp_q.delete();
    exp_next = {target[31:2], 2'b00};
  endtask

  task automatic top_up();
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  // One clock: drive inputs mid-cycle, let combinational outputs settle, then score them.
  task automatic step(input logic ready, input logic redir, input logic [31:0] rpc);
    logic [31:0] exp_pc;
    @(negedge clk);
    if (release_pending) begin
      rst_n           = 1'b1;
      release_pending = 1'b0;
    end
    bus.out_ready      = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_rdata     = prev_req ? (prev_addr ^ SIG) : $urandom();
    #1;
    cyc++;
    prev_req  = bus.imem_req;
    prev_addr = bus.imem_addr;
    if (bus.imem_req) begin
      req_count++;
      check("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
    end
    if (!bus.out_valid) begin
      check("empty_pc", bus.out_pc, 32'd0);
      check("empty_pc4", bus.out_pc_plus4, 32'd0);
      check("empty_instr", bus.out_instr, 32'd0);
    end else if (first_valid < 0) begin
      first_valid = cyc;
    end
    if (bus.out_valid && ready) begin
      hs_count++;
      top_up();
      exp_pc = exp_q.pop_front();
      check("out_pc", bus.out_pc, exp_pc);
      check("out_instr", bus.out_instr, exp_pc ^ SIG);
      check("out_pc_plus4", bus.out_pc_plus4, exp_pc + 32'd4);
    end else if (bus.out_valid) begin
      top_up();
      check("held_pc", bus.out_pc, exp_q[0]);
      check("held_instr", bus.out_instr, exp_q[0] ^ SIG);
    end
    if (redir) begin
      reseed(rpc);
      first_valid = -1;
    end
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rdata     = INSTR_NOP;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_imem_addr", bus.imem_addr, RST_PC);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_pc4", bus.out_pc_plus4, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    prev_req        = 1'b0;
    prev_addr       = '0;
    cyc             = -1;
    first_valid     = -1;
    hs_count        = 0;
    req_count       = 0;
    reseed(RST_PC);
    release_pending = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks          = 0;
    errors          = 0;
    release_pending = 1'b0;

    // Streaming from reset: first valid two cycles after release, then one per cycle.
    do_reset();
    repeat (12) step(1'b1, 1'b0, 32'd0);
    check("t1_first_valid", 32'(first_valid), 32'd2);
    check("t1_throughput", 32'(hs_count), 32'd10);

    // Decode stalled from the start: only two fetches, queue full, head parked at RESET_PC.
    do_reset();
    repeat (8) step(1'b0, 1'b0, 32'd0);
    check("t2_stall_reqs", 32'(req_count), 32'd2);
    check("t2_full_no_req", {31'd0, bus.imem_req}, 32'd0);
    check("t2_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t2_head_pc", bus.out_pc, RST_PC);
    check("t2_head_instr", bus.out_instr, RST_PC ^ SIG);
    repeat (8) step(1'b1, 1'b0, 32'd0);
    check("t2_resume_rate", 32'(hs_count), 32'd8);

    // Redirect while 0x1008 heads the queue and the 0x100C response is arriving.
    do_reset();
    repeat (4) step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_2002);
    check("t3_head_before", bus.out_pc, 32'h0000_1008);
    step(1'b1, 1'b0, 32'd0);
    check("t3_target_req", {31'd0, bus.imem_req}, 32'd1);
    check("t3_target_addr", bus.imem_addr, 32'h0000_2000);
    repeat (6) step(1'b1, 1'b0, 32'd0);
    check("t3_req_to_valid", 32'(first_valid - 5), 32'd2);

    // Redirect on the same cycle decode pops a full queue.
    repeat (4) step(1'b0, 1'b0, 32'd0);
    check("t4_full_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t4_full_no_req", {31'd0, bus.imem_req}, 32'd0);
    step(1'b1, 1'b1, 32'h0000_3000);
    step(1'b1, 1'b0, 32'd0);
    check("t4_flushed", {31'd0, bus.out_valid}, 32'd0);
    repeat (6) step(1'b1, 1'b0, 32'd0);
    check("t4_valid_seen", {31'd0, first_valid >= 0}, 32'd1);

    // Redirect to the top of the address space while streaming; PC wraps to zero.
    repeat (3) step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    hs_before = hs_count;
    repeat (6) step(1'b1, 1'b0, 32'd0);
    check("t6_wrap_count", 32'(hs_count - hs_before), 32'd4);

    // Asynchronous reset in the middle of a cycle with an instruction presented.
    check("t5_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_async_req", {31'd0, bus.imem_req}, 32'd0);
    check("t5_async_addr", bus.imem_addr, RST_PC);
    check("t5_async_pc", bus.out_pc, 32'd0);
    do_reset();
    repeat (6) step(1'b1, 1'b0, 32'd0);
    check("t5_restart_valid", 32'(first_valid), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
